debug_dump_tx: RTL

DEBUG_DUMP_TX -- requirements
Module: debug_dump_tx

---
 rtl/debug_dump_tx_pkg.sv | 31 +++
 rtl/debug_dump_tx_uart_tx.sv | 55 +++++
 rtl/debug_dump_tx.sv | 131 +++++++++++++
 3 files changed

// File: rtl/debug_dump_tx_pkg.sv
// Shared definitions for the debug dump transmitter: FSM encoding, UART frame
// constants and the order in which state sections are dumped.
package debug_dump_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } dump_state_t;

    // Sections go out in declaration order: PC, register file, data memory.
    typedef enum logic [1:0] {
        SEC_PC,
        SEC_REG,
        SEC_MEM
    } dump_sec_t;

    localparam logic UART_START_BIT  = 1'b0;
    localparam logic UART_STOP_BIT   = 1'b1;
    localparam int   UART_DATA_BITS  = 8;
    localparam int   UART_FRAME_BITS = UART_DATA_BITS + 2;
    localparam int   BYTES_PER_WORD  = 4;

    function automatic logic [UART_FRAME_BITS-1:0] uart_frame(input logic [UART_DATA_BITS-1:0] data);
        return {UART_STOP_BIT, data, UART_START_BIT};
    endfunction

endpackage

// File: rtl/debug_dump_tx_uart_tx.sv
// 8N1 UART transmitter: one frame per i_tx_start, o_tx_done asserted during the
// final clock of the stop bit so the caller can queue the next byte without idle slack.
module uart_tx
    import debug_dump_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tx_start,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [UART_FRAME_BITS-1:0] frame;
    logic [CW-1:0]              baud_cnt;
    logic [3:0]                 bit_idx;
    logic                       active;
    logic                       bit_end;

    assign bit_end   = active && (baud_cnt == CW'(CLKS_PER_BIT - 1));
    assign o_tx_done = bit_end && (bit_idx == 4'(UART_FRAME_BITS - 1));

    // Line level is the shifter LSB; reset fills it with ones so the line idles high.
    assign o_tx = frame[0];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            frame    <= '1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            active   <= 1'b0;
        end else if (!active) begin
            if (i_tx_start) begin
                frame    <= uart_frame(i_data);
                baud_cnt <= '0;
                bit_idx  <= '0;
                active   <= 1'b1;
            end
        end else if (bit_end) begin
            frame    <= {UART_STOP_BIT, frame[UART_FRAME_BITS-1:1]};
            baud_cnt <= '0;
            if (o_tx_done)
                active <= 1'b0;
            else
                bit_idx <= bit_idx + 4'd1;
        end else begin
            baud_cnt <= baud_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/debug_dump_tx.sv
// Streams PC, register file and data memory out over UART, 4 bytes per word,
// least-significant byte first.
module debug_dump_tx
    import debug_dump_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416,
    parameter int N_REGS       = 32,
    parameter int N_MEM_WORDS  = 32,
    parameter int NB_MEM_ADDR  = 5
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [31:0]            i_pc,
    output logic [4:0]             o_reg_addr,
    input  logic [31:0]            i_reg_data,
    output logic [NB_MEM_ADDR-1:0] o_mem_addr,
    input  logic [31:0]            i_mem_data,
    output logic                   o_tx,
    output logic                   o_busy,
    output logic                   o_done
);

    dump_state_t state, state_nxt;
    dump_sec_t   sec;
    logic [31:0] hold;
    logic [1:0]  byte_idx;
    logic        tx_start;
    logic        tx_done;
    logic        last_byte;
    logic        last_word;

    assign last_byte = (byte_idx == 2'(BYTES_PER_WORD - 1));
    assign last_word = (sec == SEC_MEM) && (o_mem_addr == NB_MEM_ADDR'(N_MEM_WORDS - 1));
    assign o_busy    = (state != ST_IDLE);
    assign o_done    = (state == ST_DONE);

    always_ff @(posedge i_clk) begin
        if (i_reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tx_start  = 1'b0;
        case (state)
            ST_IDLE: if (i_start) state_nxt = ST_REQ;
            ST_REQ:  state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_SEND;
            ST_SEND: begin
                tx_start  = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done) begin
                    if (!last_byte)
                        state_nxt = ST_SEND;
                    else if (last_word)
                        state_nxt = ST_DONE;
                    else
                        state_nxt = ST_REQ;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Addresses are registered so the read data lines up with LOAD one clock after REQ.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sec        <= SEC_PC;
            o_reg_addr <= '0;
            o_mem_addr <= '0;
            hold       <= '0;
            byte_idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        sec        <= SEC_PC;
                        o_reg_addr <= '0;
                        o_mem_addr <= '0;
                    end
                end
                ST_LOAD: begin
                    case (sec)
                        SEC_PC:  hold <= i_pc;
                        SEC_REG: hold <= i_reg_data;
                        default: hold <= i_mem_data;
                    endcase
                    byte_idx <= '0;
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        if (!last_byte) begin
                            byte_idx <= byte_idx + 2'd1;
                            hold     <= hold >> UART_DATA_BITS;
                        end else if (!last_word) begin
                            case (sec)
                                SEC_PC: sec <= SEC_REG;
                                SEC_REG: begin
                                    if (o_reg_addr == 5'(N_REGS - 1))
                                        sec <= SEC_MEM;
                                    else
                                        o_reg_addr <= o_reg_addr + 5'd1;
                                end
                                default: o_mem_addr <= o_mem_addr + NB_MEM_ADDR'(1);
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_tx_start (tx_start),
        .i_data     (hold[7:0]),
        .o_tx       (o_tx),
        .o_tx_done  (tx_done)
    );

endmodule
